// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lab_pkg
//  Description : Shared constants, FSM encoding and checksum helper for the
//                LAB3 sample-buffer reader.
//  Revision    : 1.0  initial release
// ============================================================================
package lab_pkg;

  localparam int NUM_CHANNELS   = 9;
  localparam int SAMPLES_PER_CH = 260;
  localparam int TOTAL_WORDS    = NUM_CHANNELS * SAMPLES_PER_CH;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [3:0] TRL_TAG = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_READ    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_TRAILER = 3'd4
  } lab_state_t;

  // Byte fold used by the trailer checksum.
  function automatic logic [7:0] fold_word(input logic [15:0] w);
    return w[15:8] ^ w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab_rd_skid.sv
`default_nettype none
// ============================================================================
//  Module      : lab_rd_skid
//  Description : Two-entry FIFO between the buffer read port and the output
//                stream. Output word is held in a register, so data is stable
//                while valid is high and not yet accepted.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i       in   clock
//    rst_n_i     in   synchronous active-low reset (empties the FIFO)
//    push_i      in   write strobe (ignored when full and not popping)
//    push_dat_i  in   word to write
//    out_valid_o out  head entry valid
//    out_dat_o   out  head entry
//    out_ready_i in   consumer accepts head entry
//    occ_o       out  number of stored entries (0..2)
// ============================================================================
module lab_rd_skid #(
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_dat_o,
  input  logic             out_ready_i,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = (r_occ != 2'd0) && out_ready_i;
  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign w_push = push_i && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) r_head <= push_dat_i;
          else               r_tail <= push_dat_i;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= push_dat_i;
          end else begin
            r_head <= r_tail;
            r_tail <= push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = (r_occ != 2'd0);
  assign out_dat_o   = r_head;
  assign occ_o       = r_occ;

endmodule
`default_nettype wire

// File: rtl/lab_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lab_buffer_reader
//  Description : Reads the LAB3 sample buffer back in address order after the
//                readout controller signals done, and streams it out as
//                header, samples, trailer over valid/ready.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i          in   system clock
//    rst_n_i        in   synchronous active-low reset
//    done_i         in   one-cycle pulse: buffer holds a complete event
//    rd_en_o        out  buffer read strobe (data returns one clock later)
//    rd_addr_o      out  buffer read address
//    rd_dat_i       in   buffer read data
//    buf_free_o     out  buffer may be overwritten
//    busy_o         out  frame in progress
//    m_dat_o        out  stream data
//    m_valid_o      out  stream valid
//    m_last_o       out  marks trailer word
//    m_ready_i      in   stream ready
//    event_cnt_o    out  completed frames, wraps
//    overrun_o      out  sticky: done_i seen while busy
//    clr_overrun_i  in   clears overrun_o
// ============================================================================
module lab_buffer_reader #(
  parameter int         NUM_CHANNELS   = lab_pkg::NUM_CHANNELS,
  parameter int         SAMPLES_PER_CH = lab_pkg::SAMPLES_PER_CH,
  parameter int         ADDR_W         = 12,
  parameter int         DATA_W         = 16,
  parameter logic [3:0] HDR_TAG        = lab_pkg::HDR_TAG,
  parameter logic [3:0] TRL_TAG        = lab_pkg::TRL_TAG
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              done_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_dat_i,
  output logic              buf_free_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] m_dat_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic [11:0]       event_cnt_o,
  output logic              overrun_o,
  input  logic              clr_overrun_i
);

  import lab_pkg::*;

  localparam int                TOTAL     = NUM_CHANNELS * SAMPLES_PER_CH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  lab_state_t        r_state;
  lab_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_trl_pushed;
  logic              r_overrun;
  logic [11:0]       r_event_cnt;
  logic [7:0]        r_chk;

  logic              w_skid_valid;
  logic [DATA_W:0]   w_skid_dat;
  logic [1:0]        w_occ;
  logic              w_pop;
  logic              w_trl_xfer;
  logic              w_accept;
  logic [2:0]        w_level;
  logic              w_rd_en;
  logic              w_trl_push;
  logic [11:0]       w_hdr_cnt;
  logic              w_push;
  logic [DATA_W:0]   w_push_dat;

  assign w_pop      = w_skid_valid && m_ready_i;
  // Only the trailer carries the last flag, so a last-word pop is the
  // trailer transfer.
  assign w_trl_xfer = w_pop && w_skid_dat[DATA_W];
  // A new frame starts from IDLE, or in the very cycle the previous trailer
  // leaves (back-to-back events).
  assign w_accept   = done_i && ((r_state == ST_IDLE) || w_trl_xfer);

  // Entries the FIFO will hold once everything already requested has landed.
  assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en    = (r_state == ST_READ) && (w_level < 3'd2);
  assign w_trl_push = (r_state == ST_TRAILER) && !r_trl_pushed &&
                      ((w_occ != 2'd2) || w_pop);
  // On a back-to-back start the header already reflects the frame just done.
  assign w_hdr_cnt  = w_trl_xfer ? (r_event_cnt + 12'd1) : r_event_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (done_i) w_state_nxt = ST_HEADER;
      ST_HEADER:  w_state_nxt = ST_READ;
      ST_READ:    if (w_rd_en && (r_addr == LAST_ADDR)) w_state_nxt = ST_DRAIN;
      // The last read was issued in the previous cycle; its data is pushed
      // at the end of this one, so a single DRAIN cycle suffices.
      ST_DRAIN:   w_state_nxt = ST_TRAILER;
      ST_TRAILER: if (w_trl_xfer) w_state_nxt = done_i ? ST_HEADER : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_push     = 1'b0;
    w_push_dat = '0;
    if (w_accept) begin
      w_push     = 1'b1;
      w_push_dat = {1'b0, DATA_W'({HDR_TAG, w_hdr_cnt})};
    end else if (r_inflight) begin
      w_push     = 1'b1;
      w_push_dat = {1'b0, rd_dat_i};
    end else if (w_trl_push) begin
      w_push     = 1'b1;
      w_push_dat = {1'b1, DATA_W'({TRL_TAG, r_overrun, 3'b000, r_chk})};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_inflight   <= 1'b0;
      r_trl_pushed <= 1'b0;
      r_overrun    <= 1'b0;
      r_event_cnt  <= 12'd0;
      r_chk        <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;

      if (w_accept)
        r_addr <= '0;
      else if (w_rd_en && (r_addr != LAST_ADDR))
        r_addr <= r_addr + ADDR_W'(1);

      if (w_accept)
        r_chk <= 8'd0;
      else if (r_inflight)
        r_chk <= r_chk ^ fold_word(rd_dat_i[15:0]);

      if (w_accept)
        r_trl_pushed <= 1'b0;
      else if (w_trl_push)
        r_trl_pushed <= 1'b1;

      if (w_trl_xfer)
        r_event_cnt <= r_event_cnt + 12'd1;

      // Setting takes priority over clearing.
      if (done_i && !w_accept)
        r_overrun <= 1'b1;
      else if (clr_overrun_i)
        r_overrun <= 1'b0;
    end
  end

  lab_rd_skid #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (w_push),
    .push_dat_i  (w_push_dat),
    .out_valid_o (w_skid_valid),
    .out_dat_o   (w_skid_dat),
    .out_ready_i (m_ready_i),
    .occ_o       (w_occ)
  );

  assign rd_en_o     = w_rd_en;
  assign rd_addr_o   = r_addr;
  assign buf_free_o  = (r_state == ST_IDLE) || (r_state == ST_DRAIN) ||
                       (r_state == ST_TRAILER);
  assign busy_o      = (r_state != ST_IDLE);
  assign m_valid_o   = w_skid_valid;
  assign m_dat_o     = w_skid_dat[DATA_W-1:0];
  assign m_last_o    = w_skid_dat[DATA_W];
  assign event_cnt_o = r_event_cnt;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lab_buffer_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lab_buffer_reader
//  Description : Directed bench for lab_buffer_reader. A full-size instance
//                covers framing, backpressure, overrun and reset; a small
//                instance (4-word buffer) covers event counter wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lab_buffer_reader;

  localparam int TOTAL0 = 2340;
  localparam int TOTAL1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---- full-size instance ----
  logic        done0, rd_en0, buf_free0, busy0, m_valid0, m_last0, ready0, ovr0, clr0;
  logic [11:0] rd_addr0, evcnt0;
  logic [15:0] rd_dat0, m_dat0;
  logic [15:0] mem0 [0:TOTAL0-1];

  lab_buffer_reader u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .done_i(done0), .rd_en_o(rd_en0),
    .rd_addr_o(rd_addr0), .rd_dat_i(rd_dat0), .buf_free_o(buf_free0),
    .busy_o(busy0), .m_dat_o(m_dat0), .m_valid_o(m_valid0), .m_last_o(m_last0),
    .m_ready_i(ready0), .event_cnt_o(evcnt0), .overrun_o(ovr0),
    .clr_overrun_i(clr0)
  );

  // ---- small instance for counter wrap ----
  logic        done1, rd_en1, buf_free1, busy1, m_valid1, m_last1, ready1, ovr1, clr1;
  logic [11:0] rd_addr1, evcnt1;
  logic [15:0] rd_dat1, m_dat1;
  logic [15:0] mem1 [0:TOTAL1-1];

  lab_buffer_reader #(.NUM_CHANNELS(1), .SAMPLES_PER_CH(4)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .done_i(done1), .rd_en_o(rd_en1),
    .rd_addr_o(rd_addr1), .rd_dat_i(rd_dat1), .buf_free_o(buf_free1),
    .busy_o(busy1), .m_dat_o(m_dat1), .m_valid_o(m_valid1), .m_last_o(m_last1),
    .m_ready_i(ready1), .event_cnt_o(evcnt1), .overrun_o(ovr1),
    .clr_overrun_i(clr1)
  );

  // Buffer models: data one clock after the strobe.
  always @(posedge clk) if (rd_en0) rd_dat0 <= mem0[rd_addr0];
  always @(posedge clk) if (rd_en1) rd_dat1 <= mem1[rd_addr1];

  logic rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    ready0 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboards hold {last, data}.
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  logic [11:0] exp_addr0 = '0;
  int          rd_cnt0 = 0, pop_cnt0 = 0;
  int          first_cyc0 = 0, s0_cyc0 = 0, last_cyc0 = 0, last_rd_cyc0 = 0;
  logic        prev_stall0 = 1'b0;
  logic [16:0] prev_word0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected frame computed from the buffer contents at start time.
  task automatic push_frame(input int which, input logic [11:0] cnt, input logic ovr);
    logic [7:0] c;
    c = 8'h00;
    if (which == 0) begin
      q0.push_back({1'b0, 4'hA, cnt});
      for (int a = 0; a < TOTAL0; a++) begin
        q0.push_back({1'b0, mem0[a]});
        c ^= mem0[a][15:8] ^ mem0[a][7:0];
      end
      q0.push_back({1'b1, 4'hF, ovr, 3'b000, c});
      pop_cnt0  = 0;
      exp_addr0 = '0;
      rd_cnt0   = 0;
    end else begin
      q1.push_back({1'b0, 4'hA, cnt});
      for (int a = 0; a < TOTAL1; a++) begin
        q1.push_back({1'b0, mem1[a]});
        c ^= mem1[a][15:8] ^ mem1[a][7:0];
      end
      q1.push_back({1'b1, 4'hF, ovr, 3'b000, c});
    end
  endtask

  // ---- output monitors ----
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (prev_stall0)
        chk("hold0", {m_valid0, m_last0, m_dat0}, {1'b1, prev_word0});
      prev_stall0 = m_valid0 && !ready0;
      prev_word0  = {m_last0, m_dat0};
      if (rd_en0) begin
        chk("rd_addr0", rd_addr0, exp_addr0);
        exp_addr0++;
        rd_cnt0++;
        last_rd_cyc0 = cyc;
      end
      if (m_valid0 && ready0) begin
        chk("extra_word0", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("word0", {m_last0, m_dat0}, e);
          if (pop_cnt0 == 0) first_cyc0 = cyc;
          if (pop_cnt0 == 1) s0_cyc0 = cyc;
          if (m_last0) last_cyc0 = cyc;
          pop_cnt0++;
        end
      end
    end else begin
      prev_stall0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && m_valid1 && ready1) begin
      chk("extra_word1", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("word1", {m_last1, m_dat1}, e);
      end
    end
  end

  task automatic wait_empty0(input int budget, input string tag);
    int n;
    n = 0;
    while (q0.size() != 0 && n < budget) begin tick(); n++; end
    chk(tag, q0.size(), 0);
  endtask

  task automatic wait_pop0(input int cnt, input int budget, input string tag);
    int n;
    n = 0;
    while (pop_cnt0 < cnt && n < budget) begin tick(); n++; end
    chk(tag, pop_cnt0 >= cnt, 1);
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_rd_en"},    rd_en0,    0);
    chk({tag, "_rd_addr"},  rd_addr0,  0);
    chk({tag, "_buf_free"}, buf_free0, 1);
    chk({tag, "_busy"},     busy0,     0);
    chk({tag, "_m_dat"},    m_dat0,    0);
    chk({tag, "_m_valid"},  m_valid0,  0);
    chk({tag, "_m_last"},   m_last0,   0);
    chk({tag, "_evcnt"},    evcnt0,    0);
    chk({tag, "_overrun"},  ovr0,      0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    done0 = 1'b0; clr0 = 1'b0; ready0 = 1'b1;
    done1 = 1'b0; clr1 = 1'b0; ready1 = 1'b1;
    for (int a = 0; a < TOTAL0; a++) mem0[a] = 16'(a);
    for (int a = 0; a < TOTAL1; a++) mem1[a] = 16'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    check_reset0("rst");
    chk("rst_free1", buf_free1, 1);

    // ---- single frame, ready held high, w[a] = a ----
    tick();
    done0 = 1'b1;
    push_frame(0, 12'd0, 1'b0);
    chk("s1_free_at_done", buf_free0, 1);
    chk("s1_busy_at_done", busy0, 0);
    tick();
    done0 = 1'b0;
    chk("s1_free_drop", buf_free0, 0);
    chk("s1_busy_rise", busy0, 1);
    chk("s1_hdr_valid", m_valid0, 1);
    chk("s1_hdr_word", m_dat0, 16'hA000);
    n = 0;
    while (!buf_free0 && n < 3000) begin tick(); n++; end
    chk("s1_free_rise", buf_free0, 1);
    chk("s1_free_after_last_rd", cyc - last_rd_cyc0, 1);
    chk("s1_rd_count_at_drain", rd_cnt0, TOTAL0);
    chk("s1_free_before_trailer", q0.size() != 0, 1);
    wait_empty0(100, "s1_frame_done");
    tick();
    chk("s1_evcnt", evcnt0, 1);
    chk("s1_hdr_to_s0_gap", (s0_cyc0 - first_cyc0) <= 3, 1);
    chk("s1_frame_cycles", (last_cyc0 - first_cyc0 + 1) <= 2345, 1);
    chk("s1_idle_busy", busy0, 0);

    // ---- same data, random backpressure ----
    rnd_ready = 1'b1;
    tick();
    done0 = 1'b1;
    push_frame(0, 12'd1, 1'b0);
    tick();
    done0 = 1'b0;
    wait_empty0(12000, "s2_frame_done");
    rnd_ready = 1'b0;
    tick();
    tick();
    chk("s2_evcnt", evcnt0, 2);
    chk("s2_rd_count", rd_cnt0, TOTAL0);
    chk("s2_overrun", ovr0, 0);

    // ---- overrun: done while busy, random data ----
    for (int a = 0; a < TOTAL0; a++) mem0[a] = 16'($urandom);
    tick();
    done0 = 1'b1;
    push_frame(0, 12'd2, 1'b1);
    tick();
    done0 = 1'b0;
    wait_pop0(1001, 3000, "s3_reach_1000");
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    chk("s3_ovr_set", ovr0, 1);
    chk("s3_still_busy", busy0, 1);
    wait_pop0(1500, 3000, "s3_reach_1500");
    done0 = 1'b1;
    clr0  = 1'b1;
    tick();
    done0 = 1'b0;
    clr0  = 1'b0;
    chk("s3_set_wins", ovr0, 1);
    wait_empty0(3000, "s3_frame_done");
    tick();
    chk("s3_ovr_sticky", ovr0, 1);
    chk("s3_evcnt", evcnt0, 3);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("s3_ovr_clear", ovr0, 0);

    // ---- reset in the middle of a frame ----
    tick();
    done0 = 1'b1;
    push_frame(0, 12'd3, 1'b0);
    tick();
    done0 = 1'b0;
    wait_pop0(500, 3000, "s4_reach_500");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    q0.delete();
    check_reset0("s4_rst");
    repeat (3) tick();
    done0 = 1'b1;
    push_frame(0, 12'd0, 1'b0);
    tick();
    done0 = 1'b0;
    chk("s4_hdr_word", m_dat0, 16'hA000);
    wait_empty0(3000, "s4_frame_done");
    tick();
    chk("s4_evcnt", evcnt0, 1);
    chk("s4_rd_count", rd_cnt0, TOTAL0);

    // ---- 4096 back-to-back events on the small instance ----
    tick();
    done1 = 1'b1;
    push_frame(1, 12'd0, 1'b0);
    tick();
    done1 = 1'b0;
    for (int ev = 1; ev <= 4096; ev++) begin
      n = 0;
      while (!(m_valid1 && m_last1) && n < 40) begin tick(); n++; end
      if (!(m_valid1 && m_last1)) begin
        chk("s5_trailer_wait", {m_valid1, m_last1}, 2'b11);
        break;
      end
      done1 = 1'b1;
      push_frame(1, 12'(ev), 1'b0);
      tick();
      done1 = 1'b0;
    end
    chk("s5_evcnt_wrap", evcnt1, 0);
    chk("s5_no_overrun", ovr1, 0);
    chk("s5_hdr4097_valid", m_valid1, 1);
    chk("s5_hdr4097_word", m_dat1, 16'hA000);
    n = 0;
    while (q1.size() != 0 && n < 40) begin tick(); n++; end
    chk("s5_last_frame_done", q1.size(), 0);
    tick();
    chk("s5_idle", busy1, 0);
    chk("s5_evcnt_final", evcnt1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
